alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_comb_core.sv | 53 +++++
 rtl/alu_exec_unit.sv | 120 ++++++++++++
 tb/tb_alu_exec_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and execution-unit FSM states.
// Used by the execution unit and the ALU controller that produces the op code.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_JAL  = 4'b0011,
        OP_SLT  = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_JALR = 4'b0111,
        OP_BEQ  = 4'b1000,
        OP_BNE  = 4'b1001,
        OP_BLT  = 4'b1010,
        OP_BGE  = 4'b1011,
        OP_ILL  = 4'b1100,
        OP_SLL  = 4'b1101,
        OP_SRL  = 4'b1110,
        OP_SRA  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } alu_state_e;

    function automatic logic is_shift_op(input alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Purely combinational ALU: result, branch condition and illegal-op flag.
// Zero latency; no flow control of its own.
// Shifts here are full barrel shifts, used only for the zero-amount shortcut.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = 5
) (
    input  alu_op_e                 op,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    branch_taken,
    output logic                    illegal
);

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic                  lt_s;
    logic [SHAMT_W-1:0]    shamt;

    assign sum   = a + b;
    assign diff  = a - b;
    assign lt_s  = $signed(a) < $signed(b);
    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        result       = '0;
        branch_taken = 1'b0;
        illegal      = 1'b0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = sum;
            OP_JAL:  result = a + DATA_WIDTH'(4);
            OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            OP_XOR:  result = a ^ b;
            OP_SUB:  result = diff;
            OP_JALR: result = {sum[DATA_WIDTH-1:1], 1'b0};
            OP_BEQ:  branch_taken = (a == b);
            OP_BNE:  branch_taken = (a != b);
            OP_BLT:  branch_taken = lt_s;
            OP_BGE:  branch_taken = ~lt_s;
            OP_ILL:  illegal = 1'b1;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops, bit-serial shifts (one position per cycle).
// Latency 1 cycle, or 1+N for a shift by N; in_ready only in IDLE, result held until out_ready.
// flush aborts anything in flight and blocks accept in the same cycle.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  BranchTaken,
    output logic                  IllegalOp
);

    alu_state_e            state, state_nxt;
    alu_op_e               op_in, op_q;
    logic [DATA_WIDTH-1:0] shreg, sh_step;
    logic [SHAMT_W-1:0]    cnt;
    logic [SHAMT_W-1:0]    shamt_in;
    logic [DATA_WIDTH-1:0] result_q, core_result;
    logic                  br_q, ill_q, core_br, core_ill;
    logic                  accept, start_shift, last_step;

    assign op_in       = alu_op_e'(Operation);
    assign shamt_in    = SrcB[SHAMT_W-1:0];
    assign in_ready    = (state == ST_IDLE);
    assign out_valid   = (state == ST_DONE);
    assign accept      = in_valid & in_ready & ~flush;
    assign start_shift = is_shift_op(op_in) && (shamt_in != '0);
    assign last_step   = (state == ST_SHIFT) && (cnt == SHAMT_W'(1));

    assign ALUResult   = result_q;
    assign BranchTaken = br_q;
    assign IllegalOp   = ill_q;

    alu_comb_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHAMT_W    (SHAMT_W)
    ) u_core (
        .op           (op_in),
        .a            (SrcA),
        .b            (SrcB),
        .result       (core_result),
        .branch_taken (core_br),
        .illegal      (core_ill)
    );

    always_comb begin
        sh_step = {shreg[DATA_WIDTH-1], shreg[DATA_WIDTH-1:1]};
        case (op_q)
            OP_SLL:  sh_step = {shreg[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  sh_step = {1'b0, shreg[DATA_WIDTH-1:1]};
            default: sh_step = {shreg[DATA_WIDTH-1], shreg[DATA_WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept) state_nxt = start_shift ? ST_SHIFT : ST_DONE;
                ST_SHIFT: if (last_step) state_nxt = ST_DONE;
                ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Result registers only move in IDLE/SHIFT, so outputs are frozen throughout DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_AND;
            shreg    <= '0;
            cnt      <= '0;
            result_q <= '0;
            br_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                op_q <= op_in;
                if (start_shift) begin
                    shreg <= SrcA;
                    cnt   <= shamt_in;
                end else begin
                    result_q <= core_result;
                    br_q     <= core_br;
                    ill_q    <= core_ill;
                end
            end
        end else if (state == ST_SHIFT) begin
            shreg <= sh_step;
            cnt   <= cnt - SHAMT_W'(1);
            if (last_step) begin
                result_q <= sh_step;
                br_q     <= 1'b0;
                ill_q    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        BranchTaken;
    logic        IllegalOp;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.DATA_WIDTH(32), .SHAMT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .Operation   (Operation),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALUResult   (ALUResult),
        .BranchTaken (BranchTaken),
        .IllegalOp   (IllegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one edge; returns 1ns after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        step();
        in_valid  = 1'b0;
    endtask

    // Latency counted in cycles from the accept cycle; also reports whether in_ready rose meanwhile.
    task automatic wait_valid(output int lat, output logic rdy_seen);
        lat      = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            step();
            lat++;
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_ovld_after"}, {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_br, input logic exp_ill, input int exp_lat);
        int   lat;
        logic rdy;
        send(op, a, b);
        wait_valid(lat, rdy);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, ALUResult, exp_res);
        check({tag, "_br"},  {31'b0, BranchTaken}, {31'b0, exp_br});
        check({tag, "_ill"}, {31'b0, IllegalOp}, {31'b0, exp_ill});
        consume(tag);
    endtask

    initial begin
        int          lat;
        logic        rdy;
        logic        bad;
        logic [31:0] held;

        rst_n = 1'b0; in_valid = 1'b0; Operation = 4'd0; SrcA = '0; SrcB = '0;
        flush = 1'b0; out_ready = 1'b0;
        #2;
        check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result",    ALUResult, 32'd0);
        check("rst_branch",    {31'b0, BranchTaken}, 32'd0);
        check("rst_illegal",   {31'b0, IllegalOp}, 32'd0);
        #10 rst_n = 1'b1;
        step();

        // ADD overflow wraps, consumer already ready.
        out_ready = 1'b1;
        send(4'b0010, 32'h7FFF_FFFF, 32'd1);
        wait_valid(lat, rdy);
        check("add_lat", lat, 1);
        check("add_res", ALUResult, 32'h8000_0000);
        step();
        check("add_ovld_after", {31'b0, out_valid}, 32'd0);
        check("add_ready_after", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b0;

        // SRA by 4 (upper SrcB bits ignored); in_ready low until done.
        send(4'b1111, 32'h8000_0000, 32'h0000_0024);
        wait_valid(lat, rdy);
        check("sra_lat", lat, 5);
        check("sra_res", ALUResult, 32'hF800_0000);
        check("sra_rdy_low", {31'b0, rdy}, 32'd0);
        check("sra_rdy_done", {31'b0, in_ready}, 32'd0);
        consume("sra");

        run("blt",  4'b1010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
        run("bge",  4'b1011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1);
        run("beq",  4'b1000, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0, 1);
        run("slt",  4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
        run("sub",  4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
        run("xor",  4'b0101, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1'b0, 1'b0, 1);
        run("and",  4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0, 1);
        run("jal",  4'b0011, 32'h0000_0100, 32'h55, 32'h0000_0104, 1'b0, 1'b0, 1);
        run("jalr", 4'b0111, 32'h0000_1000, 32'h7, 32'h0000_1006, 1'b0, 1'b0, 1);
        run("ill",  4'b1100, 32'd5, 32'd3, 32'd0, 1'b0, 1'b1, 1);
        run("sll0", 4'b1101, 32'h1234, 32'h20, 32'h1234, 1'b0, 1'b0, 1);
        run("srl1", 4'b1110, 32'hF0, 32'hFFFF_FFE1, 32'h78, 1'b0, 1'b0, 2);

        // SLL by 31 held for 10 cycles with out_ready low.
        send(4'b1101, 32'd1, 32'd31);
        wait_valid(lat, rdy);
        check("sll31_lat", lat, 32);
        check("sll31_res", ALUResult, 32'h8000_0000);
        held = ALUResult;
        bad  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!out_valid || ALUResult !== held || in_ready) bad = 1'b1;
        end
        check("sll31_hold", {31'b0, bad}, 32'd0);
        consume("sll31");
        check("sll31_ready_after", {31'b0, in_ready}, 32'd1);

        // Flush in 3rd SHIFT cycle of SRL by 20.
        send(4'b1110, 32'hFFFF_FFFF, 32'd20);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_idle", {31'b0, in_ready}, 32'd1);
        check("flush_ovld", {31'b0, out_valid}, 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid) bad = 1'b1;
        end
        check("flush_no_pulse", {31'b0, bad}, 32'd0);

        // Reset pulse mid-SHIFT.
        send(4'b1110, 32'hFFFF_FFFF, 32'd20);
        step();
        step();
        rst_n = 1'b0;
        #2;
        check("rst_mid_ready", {31'b0, in_ready}, 32'd1);
        check("rst_mid_result", ALUResult, 32'd0);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid) bad = 1'b1;
        end
        check("rst_mid_no_pulse", {31'b0, bad}, 32'd0);

        // Flush coinciding with in_valid blocks the accept.
        in_valid = 1'b1; Operation = 4'b0010; SrcA = 32'd1; SrcB = 32'd2;
        flush = 1'b1;
        step();
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_blocks_ovld", {31'b0, out_valid}, 32'd0);
        check("flush_blocks_ready", {31'b0, in_ready}, 32'd1);

        // Unit still works after all aborts.
        run("or_after", 4'b0001, 32'hA0, 32'h0B, 32'hAB, 1'b0, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
